// File: rtl/abc_seq_pkg.sv
// ==== abc_seq_pkg : shared state encoding, counter width and table-width helper  (rev 1.0) ====
`default_nettype none

package abc_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_t;

  localparam int CNT_W = 8;

  function automatic int TBL_W(input int n);
    return 2 ** n;
  endfunction

endpackage

`default_nettype wire

// File: rtl/seq_settle_timer.sv
// ==== seq_settle_timer : per-vector hold counter with terminal-count flag  (rev 1.0) ====
`default_nettype none

module seq_settle_timer
  import abc_seq_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic en,
  output logic tc
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign tc = (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (en) begin
      // Restart at the sample edge so each vector gets exactly SETTLE_CYCLES cycles.
      cnt <= tc ? '0 : cnt + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/abc_stimulus_sequencer.sv
// ==== abc_stimulus_sequencer : sweeps {A,B,C} and captures z into a truth table  (rev 1.0) ====
// ==== optional expected-table compare enabled by defining SEQ_COMPARE_EN ====
`default_nettype none

module abc_stimulus_sequencer
  import abc_seq_pkg::*;
#(
  parameter  int N_IN          = 3,
  parameter  int SETTLE_CYCLES = 2,
  localparam int TBL           = TBL_W(N_IN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            z,
  input  logic [TBL-1:0]  exp_table,
  output logic [N_IN-1:0] abc,
  output logic            busy,
  output logic            done,
  output logic [TBL-1:0]  truth_table,
  output logic            mismatch,
  output logic [N_IN-1:0] first_fail
);

  localparam logic [N_IN-1:0] IDX_LAST = '1;

  seq_state_t      state;
  logic [N_IN-1:0] idx;
  logic            tc;
  logic            accept;
  logic            sample;

  assign accept = (state == IDLE) && start;
  // Abort has priority over a coincident sample: the bit is left unwritten.
  assign sample = (state == RUN) && !abort && tc;
  assign abc    = idx;

  seq_settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_timer (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(accept || ((state == RUN) && abort)),
    .en   (state == RUN),
    .tc   (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      idx         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      truth_table <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state       <= RUN;
            idx         <= '0;
            busy        <= 1'b1;
            truth_table <= '0;
          end
        end
        RUN: begin
          if (abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (tc) begin
            truth_table[idx] <= z;
            if (idx == IDX_LAST) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

`ifdef SEQ_COMPARE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch   <= 1'b0;
      first_fail <= '0;
    end else if (accept) begin
      mismatch   <= 1'b0;
      first_fail <= '0;
    end else if (sample && (z != exp_table[idx])) begin
      mismatch <= 1'b1;
      if (!mismatch) begin
        first_fail <= idx;
      end
    end
  end
`else
  logic unused_exp_table;
  assign unused_exp_table = ^exp_table;
  assign mismatch         = 1'b0;
  assign first_fail       = '0;
`endif

endmodule

`default_nettype wire
